// File: rtl/mseq_pkg.sv
// Shared encodings for the microstore next-state sequencer.
// NS_* selects the next-state operation, STS_* selects the status bit under test.
package mseq_pkg;

    typedef enum logic [2:0] {
        NS_INC   = 3'd0,
        NS_JMP   = 3'd1,
        NS_DISP  = 3'd2,
        NS_BR    = 3'd3,
        NS_CALL  = 3'd4,
        NS_RET   = 3'd5,
        NS_WAIT  = 3'd6,
        NS_FETCH = 3'd7
    } ns_op_e;

    typedef enum logic [1:0] {
        STS_COND = 2'd0,
        STS_MOC  = 2'd1,
        STS_TRAP = 2'd2,
        STS_ONE  = 2'd3
    } sts_sel_e;

endpackage

// File: rtl/mseq_if.sv
// Control-pipeline fields and status inputs into the sequencer, plus its outputs.
// The sequencer sits on the slave side; the pipeline/status source is the master.
interface mseq_if #(
    parameter int STATE_W = 8
) ();
    logic [2:0]         NS_select;
    logic               Inv;
    logic               CT_select;
    logic [1:0]         Sts_select;
    logic [STATE_W-1:0] Pl7;
    logic [STATE_W-1:0] Enc_state;
    logic               Cond;
    logic               MOC;
    logic               Trap_req;
    logic [STATE_W-1:0] State;
    logic               Stall;
    logic               Stk_err;
    logic               Wait_tmo;

    modport slave (
        input  NS_select, Inv, CT_select, Sts_select, Pl7, Enc_state,
        input  Cond, MOC, Trap_req,
        output State, Stall, Stk_err, Wait_tmo
    );

    modport master (
        output NS_select, Inv, CT_select, Sts_select, Pl7, Enc_state,
        output Cond, MOC, Trap_req,
        input  State, Stall, Stk_err, Wait_tmo
    );
endinterface

// File: rtl/mseq_return_stack.sv
// LIFO of micro-call return addresses. Pushes on full and pops on empty are
// ignored here; the caller decides how those are reported.
module mseq_return_stack #(
    parameter int STACK_DEPTH = 4,
    parameter int STATE_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic [STATE_W-1:0] din,
    output logic [STATE_W-1:0] dout,
    output logic               full,
    output logic               empty
);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    // Storage rounded up to a power of two so sp indexes it without width games.
    localparam int MEM_N = 1 << SP_W;

    logic [SP_W-1:0]    sp_q, sp_d, top_idx;
    logic [STATE_W-1:0] mem_q [MEM_N];
    logic [STATE_W-1:0] mem_d [MEM_N];

    assign full    = (sp_q == SP_W'(STACK_DEPTH));
    assign empty   = (sp_q == '0);
    assign top_idx = sp_q - SP_W'(1);
    assign dout    = mem_q[top_idx];

    always_comb begin
        sp_d  = sp_q;
        mem_d = mem_q;
        if (push && !full) begin
            mem_d[sp_q] = din;
            sp_d        = sp_q + SP_W'(1);
        end else if (pop && !empty) begin
            sp_d = sp_q - SP_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sp_q <= '0;
        else        sp_q <= sp_d;
    end

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/microstore_sequencer.sv
// Microstore next-state sequencer: State register, condition mux, wait timer, error flags.
// Optional feature: define MSEQ_TRAP_EN to divert DISP to TRAP_STATE when Trap_req is set.
module microstore_sequencer
    import mseq_pkg::*;
#(
    parameter int STATE_W     = 8,
    parameter int RESET_STATE = 0,
    parameter int FETCH_STATE = 1,
    parameter int TRAP_STATE  = 2,
    parameter int STACK_DEPTH = 4,
    parameter int WAIT_MAX    = 16
) (
    input logic   Clk,
    input logic   Rst_n,
    mseq_if.slave bus
);
    localparam int WC_W = $clog2(WAIT_MAX);

    logic [STATE_W-1:0] state_q, state_d, inc, push_din, stk_dout;
    logic [WC_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic               stk_err_q, stk_err_d, wait_tmo_q, wait_tmo_d;
    logic               push, pop, stk_full, stk_empty;
    logic               trap_eff, c, stall;
    logic [3:0]         sts;

`ifdef MSEQ_TRAP_EN
    assign trap_eff = bus.Trap_req;
`else
    logic unused_trap_req;
    assign unused_trap_req = bus.Trap_req;
    assign trap_eff        = 1'b0;
`endif

    assign sts = {1'b1, trap_eff, bus.MOC, bus.Cond};
    assign c   = (bus.CT_select ? sts[bus.Sts_select] : 1'b1) ^ bus.Inv;
    assign inc = state_q + STATE_W'(1);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        stk_err_d  = stk_err_q;
        wait_tmo_d = wait_tmo_q;
        push       = 1'b0;
        pop        = 1'b0;
        push_din   = inc;
        stall      = 1'b0;
        case (ns_op_e'(bus.NS_select))
            NS_INC:  state_d = inc;
            NS_JMP:  state_d = bus.Pl7;
            NS_DISP: begin
                if (trap_eff) begin
                    state_d  = STATE_W'(TRAP_STATE);
                    push_din = bus.Enc_state;
                    if (stk_full) stk_err_d = 1'b1;
                    else          push      = 1'b1;
                end else begin
                    state_d = bus.Enc_state;
                end
            end
            NS_BR:   state_d = c ? bus.Pl7 : inc;
            NS_CALL: begin
                state_d = bus.Pl7;
                if (stk_full) stk_err_d = 1'b1;
                else          push      = 1'b1;
            end
            NS_RET: begin
                if (stk_empty) begin
                    state_d   = STATE_W'(FETCH_STATE);
                    stk_err_d = 1'b1;
                end else begin
                    state_d = stk_dout;
                    pop     = 1'b1;
                end
            end
            NS_WAIT: begin
                if (c) begin
                    state_d = inc;
                end else begin
                    stall = 1'b1;
                    // The WAIT_MAX-th consecutive stalled cycle gives up and recovers to fetch.
                    if (wait_cnt_q == WC_W'(WAIT_MAX - 1)) begin
                        state_d    = STATE_W'(FETCH_STATE);
                        wait_tmo_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WC_W'(1);
                    end
                end
            end
            NS_FETCH: state_d = STATE_W'(FETCH_STATE);
            default:  state_d = inc;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= STATE_W'(RESET_STATE);
            wait_cnt_q <= '0;
            stk_err_q  <= 1'b0;
            wait_tmo_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            stk_err_q  <= stk_err_d;
            wait_tmo_q <= wait_tmo_d;
        end
    end

    mseq_return_stack #(
        .STACK_DEPTH (STACK_DEPTH),
        .STATE_W     (STATE_W)
    ) u_stack (
        .clk   (Clk),
        .rst_n (Rst_n),
        .push  (push),
        .pop   (pop),
        .din   (push_din),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

    assign bus.State    = state_q;
    assign bus.Stall    = stall;
    assign bus.Stk_err  = stk_err_q;
    assign bus.Wait_tmo = wait_tmo_q;
endmodule

// File: tb/tb_microstore_sequencer.sv
// Directed + random bench for microstore_sequencer against a queue-based next-state model.
// Build with or without MSEQ_TRAP_EN; the model follows the same macro.
module tb_microstore_sequencer;
    localparam int W     = 8;
    localparam int FETCH = 1;
    localparam int TRAP  = 2;
    localparam int DEPTH = 4;
    localparam int WMAX  = 16;

    logic Clk, Rst_n;
    mseq_if #(.STATE_W(W)) bus ();

    microstore_sequencer #(
        .STATE_W(W), .RESET_STATE(0), .FETCH_STATE(FETCH), .TRAP_STATE(TRAP),
        .STACK_DEPTH(DEPTH), .WAIT_MAX(WMAX)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 1'b0;

    logic [W-1:0] m_state;
    logic [W-1:0] m_stk[$];
    int           m_wc;
    bit           m_serr, m_tmo;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic bit trap_in();
`ifdef MSEQ_TRAP_EN
        return bus.Trap_req;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_cond();
        bit s;
        case (bus.Sts_select)
            2'd0: s = bus.Cond;
            2'd1: s = bus.MOC;
            2'd2: s = trap_in();
            default: s = 1'b1;
        endcase
        return (bus.CT_select ? s : 1'b1) ^ bus.Inv;
    endfunction

    function automatic bit m_stall();
        return (bus.NS_select == 3'd6) && !m_cond();
    endfunction

    task automatic m_reset();
        m_state = '0;
        m_stk.delete();
        m_wc   = 0;
        m_serr = 0;
        m_tmo  = 0;
    endtask

    // Work out the next state from the present inputs, commit it at the edge.
    task automatic tick();
        logic [W-1:0] nx;
        int  wc_n, do_push, do_pop;
        logic [W-1:0] pv;
        bit serr_n, tmo_n, c;
        c = m_cond(); nx = m_state; wc_n = 0; do_push = 0; do_pop = 0;
        pv = m_state + 8'd1; serr_n = m_serr; tmo_n = m_tmo;
        case (bus.NS_select)
            3'd0: nx = m_state + 8'd1;
            3'd1: nx = bus.Pl7;
            3'd2: if (trap_in()) begin
                      nx = TRAP; pv = bus.Enc_state;
                      if (m_stk.size() < DEPTH) do_push = 1; else serr_n = 1;
                  end else nx = bus.Enc_state;
            3'd3: nx = c ? bus.Pl7 : m_state + 8'd1;
            3'd4: begin
                      nx = bus.Pl7;
                      if (m_stk.size() < DEPTH) do_push = 1; else serr_n = 1;
                  end
            3'd5: if (m_stk.size() > 0) begin nx = m_stk[$]; do_pop = 1; end
                  else begin nx = FETCH; serr_n = 1; end
            3'd6: if (c) nx = m_state + 8'd1;
                  else if (m_wc == WMAX - 1) begin nx = FETCH; tmo_n = 1; end
                  else wc_n = m_wc + 1;
            default: nx = FETCH;
        endcase
        @(posedge Clk);
        m_state = nx; m_wc = wc_n; m_serr = serr_n; m_tmo = tmo_n;
        if (do_push) m_stk.push_back(pv);
        if (do_pop)  void'(m_stk.pop_back());
        #1;
    endtask

    task automatic set_in(input logic [2:0] ns, input logic [W-1:0] pl7 = '0,
                          input bit ct = 0, input logic [1:0] ss = 0, input bit inv = 0,
                          input bit cond = 0, input bit moc = 0, input bit trap = 0,
                          input logic [W-1:0] enc = '0);
        bus.NS_select = ns; bus.Pl7 = pl7; bus.CT_select = ct; bus.Sts_select = ss;
        bus.Inv = inv; bus.Cond = cond; bus.MOC = moc; bus.Trap_req = trap; bus.Enc_state = enc;
    endtask

    task automatic op(input logic [2:0] ns, input logic [W-1:0] pl7 = '0);
        set_in(ns, pl7);
        tick();
    endtask

    // Called just after a posedge: pulls reset low mid-cycle, releases it before the next edge.
    task automatic pulse_reset();
        #2 Rst_n = 1'b0;
        m_reset();
        #1;
        chk("rst_state", bus.State, 0);
        chk("rst_stk_err", bus.Stk_err, 0);
        chk("rst_wait_tmo", bus.Wait_tmo, 0);
        #1 Rst_n = 1'b1;
    endtask

    always @(negedge Clk) begin
        if (cmp_en && Rst_n) begin
            chk("state", bus.State, m_state);
            chk("stall", bus.Stall, m_stall());
            chk("stk_err", bus.Stk_err, m_serr);
            chk("wait_tmo", bus.Wait_tmo, m_tmo);
        end
    end

    initial begin
        Rst_n = 1'b0;
        set_in(3'd0);
        m_reset();
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_state", bus.State, 0);
        Rst_n = 1'b1;
        cmp_en = 1'b1;

        // Increment and wrap
        op(3'd0); chk("inc1", bus.State, 1);
        op(3'd0); chk("inc2", bus.State, 2);
        op(3'd0); chk("inc3", bus.State, 3);
        op(3'd1, 8'hFF); op(3'd0); chk("inc_wrap", bus.State, 8'h00);

        // Conditional branch, both polarities
        op(3'd1, 8'd5);
        set_in(3'd3, 8'h40, 1, 2'd0, 0, 1); tick(); chk("br_taken", bus.State, 8'h40);
        op(3'd1, 8'd5);
        set_in(3'd3, 8'h40, 1, 2'd0, 1, 1); tick(); chk("br_inv", bus.State, 8'd6);

        // Call / return
        op(3'd1, 8'd9);
        op(3'd4, 8'h20); chk("call", bus.State, 8'h20);
        op(3'd5);        chk("ret", bus.State, 8'h0A);
        chk("ret_no_err", bus.Stk_err, 0);
        for (int i = 0; i < 4; i++) op(3'd4, 8'h50 + 8'(i));
        chk("call4_no_err", bus.Stk_err, 0);
        op(3'd4, 8'h60);
        chk("call5_overflow", bus.Stk_err, 1);
        chk("call5_jump", bus.State, 8'h60);
        op(3'd5); chk("ret_after_ovf", bus.State, 8'h53);

        // Underflow from a fresh stack
        pulse_reset();
        op(3'd5); chk("ret_empty_state", bus.State, FETCH);
        chk("ret_empty_err", bus.Stk_err, 1);

        // WAIT on MOC: three stalls then release
        pulse_reset();
        op(3'd1, 8'h10);
        for (int i = 0; i < 3; i++) begin
            set_in(3'd6, 0, 1, 2'd1, 0, 0, 0);
            #1 chk("wait_stall", bus.Stall, 1);
            tick(); chk("wait_hold", bus.State, 8'h10);
        end
        set_in(3'd6, 0, 1, 2'd1, 0, 0, 1);
        #1 chk("wait_release_stall", bus.Stall, 0);
        tick(); chk("wait_release", bus.State, 8'h11);

        // WAIT timeout
        set_in(3'd6, 0, 1, 2'd1, 0, 0, 0);
        repeat (WMAX - 1) tick();
        chk("tmo_before_state", bus.State, 8'h11);
        chk("tmo_before_flag", bus.Wait_tmo, 0);
        tick();
        chk("tmo_state", bus.State, FETCH);
        chk("tmo_flag", bus.Wait_tmo, 1);

        // Async reset mid-WAIT with two stacked returns and both flags set
        op(3'd4, 8'h30); op(3'd4, 8'h31);
        op(3'd5); op(3'd5); op(3'd5);
        op(3'd4, 8'h30); op(3'd4, 8'h31);
        chk("pre_rst_err", bus.Stk_err, 1);
        set_in(3'd6, 0, 1, 2'd1, 0, 0, 0);
        tick(); tick();
        pulse_reset();
        op(3'd5);
        chk("post_rst_sp0", bus.State, FETCH);
        chk("post_rst_sp0_err", bus.Stk_err, 1);

        // Dispatch with a pending trap
        pulse_reset();
        set_in(3'd2, 0, 0, 0, 0, 0, 0, 1, 8'h30); tick();
`ifdef MSEQ_TRAP_EN
        chk("disp_trap", bus.State, TRAP);
        op(3'd5); chk("trap_ret", bus.State, 8'h30);
`else
        chk("disp_no_trap", bus.State, 8'h30);
`endif

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) pulse_reset();
            set_in(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 2'($urandom),
                   1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom_range(0, 4) != 0),
                   1'($urandom), 8'($urandom));
            tick();
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
